// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU pipeline control: sequencer states,
// default timing constants and the hard-wired zero register.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALTED   = 3'd4
  } seq_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int MEM_TIMEOUT_DEF  = 64;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational register compare between a load in EX and the instruction in ID.
module load_use_detect
  import cpu_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       hazard
);

  // A load into r0 never produces a real dependency.
  assign hazard = mem_read && (ex_rt != REG_ZERO) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: start, load-use stalls, branch flushes,
// memory freezes with timeout, and halt drain for the 5-stage CPU.
module pipeline_sequencer
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       IFID_RSaddr_i,
  input  logic [4:0]       IFID_RTaddr_i,
  input  logic             IFID_uses_rt_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RTaddr_i,
  input  logic             branch_taken_i,
  input  logic             halt_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             pipe_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [2:0]       state_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

  seq_state_e         state, ret_state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic               err;

  seq_state_e         next_state, next_ret;
  logic [DRAIN_W-1:0] next_drain;
  logic [WAIT_W-1:0]  next_wait;
  logic               stall_inc, set_err;
  logic               freeze, hazard, do_run, do_drain;

  load_use_detect u_load_use (
    .mem_read   (IDEX_MemRead_i),
    .ex_rt      (IDEX_RTaddr_i),
    .id_rs      (IFID_RSaddr_i),
    .id_rt      (IFID_RTaddr_i),
    .id_uses_rt (IFID_uses_rt_i),
    .hazard     (hazard)
  );

  assign freeze = dmem_req_i && !dmem_ready_i;

  // The ready cycle of a wait behaves like an unfrozen cycle of the return state.
  assign do_run   = ((state == ST_RUN) && !freeze) ||
                    ((state == ST_MEM_WAIT) && dmem_ready_i && (ret_state == ST_RUN));
  assign do_drain = ((state == ST_DRAIN) && !freeze) ||
                    ((state == ST_MEM_WAIT) && dmem_ready_i && (ret_state == ST_DRAIN));

  always_comb begin
    PCWrite_o     = 1'b0;
    IFIDWrite_o   = 1'b0;
    IFID_flush_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    pipe_en_o     = 1'b0;
    next_state    = state;
    next_ret      = ret_state;
    next_drain    = drain_cnt;
    next_wait     = wait_cnt;
    stall_inc     = 1'b0;
    set_err       = 1'b0;

    case (state)
      ST_IDLE: begin
        IDEX_bubble_o = 1'b1;
        if (start_i) next_state = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        IDEX_bubble_o = (state == ST_DRAIN);
        if (freeze) begin
          next_state = ST_MEM_WAIT;
          next_ret   = state;
          next_wait  = WAIT_W'(1);
          stall_inc  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_i) begin
          next_wait  = '0;
          next_state = ret_state;
        end else begin
          stall_inc = 1'b1;
          if (int'(wait_cnt) + 1 >= MEM_TIMEOUT) begin
            next_state = ST_HALTED;
            next_wait  = '0;
            set_err    = 1'b1;
          end else begin
            next_wait = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ST_HALTED: IDEX_bubble_o = 1'b1;
      default: begin
        IDEX_bubble_o = 1'b1;
        next_state    = ST_IDLE;
      end
    endcase

    // Branch beats load-use beats halt; a wrong-path ID instruction is discarded.
    if (do_run) begin
      next_state = ST_RUN;
      pipe_en_o  = 1'b1;
      if (branch_taken_i) begin
        PCWrite_o     = 1'b1;
        IFIDWrite_o   = 1'b1;
        IFID_flush_o  = 1'b1;
        IDEX_bubble_o = 1'b1;
      end else if (hazard) begin
        IDEX_bubble_o = 1'b1;
        stall_inc     = 1'b1;
      end else begin
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        if (halt_i) begin
          next_state = ST_DRAIN;
          next_drain = '0;
        end
      end
    end

    if (do_drain) begin
      pipe_en_o     = 1'b1;
      IDEX_bubble_o = 1'b1;
      next_drain    = drain_cnt + DRAIN_W'(1);
      next_state    = (int'(drain_cnt) + 1 >= DRAIN_CYCLES) ? ST_HALTED : ST_DRAIN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      ret_state <= ST_IDLE;
      drain_cnt <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      ret_state <= next_ret;
      drain_cnt <= next_drain;
      wait_cnt  <= next_wait;
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (set_err)
        err <= 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign state_o     = state;
  assign err_o       = err;
  assign done_o      = (state == ST_HALTED) && !err;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer, built with an
// 8-cycle memory timeout so the timeout path is reachable quickly.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  rsAddr, rtAddr, exRt;
  logic        usesRt, memRead, branchTaken, halt, dmemReq, dmemReady;
  logic        pcWrite, ifidWrite, ifidFlush, idexBubble, pipeEn, done, err;
  logic [15:0] stallCnt;
  logic [2:0]  state;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .DRAIN_CYCLES (3),
    .MEM_TIMEOUT  (8),
    .CNT_W        (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .IFID_RSaddr_i  (rsAddr),
    .IFID_RTaddr_i  (rtAddr),
    .IFID_uses_rt_i (usesRt),
    .IDEX_MemRead_i (memRead),
    .IDEX_RTaddr_i  (exRt),
    .branch_taken_i (branchTaken),
    .halt_i         (halt),
    .dmem_req_i     (dmemReq),
    .dmem_ready_i   (dmemReady),
    .PCWrite_o      (pcWrite),
    .IFIDWrite_o    (ifidWrite),
    .IFID_flush_o   (ifidFlush),
    .IDEX_bubble_o  (idexBubble),
    .pipe_en_o      (pipeEn),
    .stall_cnt_o    (stallCnt),
    .state_o        (state),
    .done_o         (done),
    .err_o          (err)
  );

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives all functional inputs, then waits to the falling edge for sampling.
  task automatic applyStimulus(input logic st, input logic mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                               input logic br, input logic hl, input logic rq, input logic rd);
    start = st; memRead = mr; exRt = ert; rsAddr = rs; rtAddr = rt; usesRt = urt;
    branchTaken = br; halt = hl; dmemReq = rq; dmemReady = rd;
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    rst = 1'b0;

    // Reset state and start
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_pcwrite", pcWrite, 0);
    checkOutput("rst_ifidwrite", ifidWrite, 0);
    checkOutput("rst_flush", ifidFlush, 0);
    checkOutput("rst_pipe_en", pipeEn, 0);
    checkOutput("rst_bubble", idexBubble, 1);
    checkOutput("rst_stall", stallCnt, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("start_cycle_state", state, 0);
    checkOutput("start_cycle_pcwrite", pcWrite, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("run_state", state, 1);
    checkOutput("run_pcwrite", pcWrite, 1);
    checkOutput("run_ifidwrite", ifidWrite, 1);
    checkOutput("run_pipe_en", pipeEn, 1);
    checkOutput("run_bubble", idexBubble, 0);

    // Load-use on rs
    nextCycle();
    applyStimulus(0, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_pcwrite", pcWrite, 0);
    checkOutput("lu_ifidwrite", ifidWrite, 0);
    checkOutput("lu_bubble", idexBubble, 1);
    checkOutput("lu_pipe_en", pipeEn, 1);
    checkOutput("lu_stall_before", stallCnt, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_stall_after", stallCnt, 1);
    checkOutput("lu_released", pcWrite, 1);

    // Load into r0 is never a hazard
    nextCycle();
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("lu_r0_pcwrite", pcWrite, 1);
    checkOutput("lu_r0_bubble", idexBubble, 0);

    // Load-use on rt counts only when the ID instruction reads rt
    nextCycle();
    applyStimulus(0, 1, 7, 3, 7, 1, 0, 0, 0, 0);
    checkOutput("lu_rt_pcwrite", pcWrite, 0);
    checkOutput("lu_rt_stall", stallCnt, 1);
    nextCycle();
    applyStimulus(0, 1, 7, 3, 7, 0, 0, 0, 0, 0);
    checkOutput("lu_rt_unused_pcwrite", pcWrite, 1);
    checkOutput("lu_rt_stall_after", stallCnt, 2);

    // Memory wait of 4 frozen cycles, then ready
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("mw_entry_state", state, 1);
    checkOutput("mw_entry_pipe_en", pipeEn, 0);
    checkOutput("mw_entry_pcwrite", pcWrite, 0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("mw_wait_state", state, 2);
      checkOutput("mw_wait_pipe_en", pipeEn, 0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("mw_ready_state", state, 2);
    checkOutput("mw_ready_pipe_en", pipeEn, 1);
    checkOutput("mw_ready_pcwrite", pcWrite, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mw_back_state", state, 1);
    checkOutput("mw_stall", stallCnt, 6);

    // Branch with a matching load-use and halt: flush wins
    nextCycle();
    applyStimulus(0, 1, 5, 5, 0, 0, 1, 1, 0, 0);
    checkOutput("br_flush", ifidFlush, 1);
    checkOutput("br_bubble", idexBubble, 1);
    checkOutput("br_pcwrite", pcWrite, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("br_no_drain", state, 1);
    checkOutput("br_stall", stallCnt, 6);
    checkOutput("br_flush_clear", ifidFlush, 0);

    // Halt at N with a 2-cycle wait in the second drain cycle
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("halt_n_state", state, 1);
    checkOutput("halt_n_pcwrite", pcWrite, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_n1_state", state, 3);
    checkOutput("halt_n1_pipe_en", pipeEn, 1);
    checkOutput("halt_n1_pcwrite", pcWrite, 0);
    checkOutput("halt_n1_bubble", idexBubble, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("halt_n2_state", state, 3);
    checkOutput("halt_n2_pipe_en", pipeEn, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("halt_n3_state", state, 2);
    checkOutput("halt_n3_pipe_en", pipeEn, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("halt_n4_pipe_en", pipeEn, 1);
    checkOutput("halt_n4_done", done, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_n5_state", state, 3);
    checkOutput("halt_n5_done", done, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_n6_state", state, 4);
    checkOutput("halt_n6_done", done, 1);
    checkOutput("halt_n6_err", err, 0);
    checkOutput("halt_stall", stallCnt, 8);
    checkOutput("halted_pcwrite", pcWrite, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halted_ignores_start", state, 4);

    // Memory timeout after 8 frozen cycles
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_reset_state", state, 0);
    checkOutput("to_reset_stall", stallCnt, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("to_entry_state", state, 1);
    for (int i = 1; i <= 7; i++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("to_wait_state", state, 2);
    end
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("to_state", state, 4);
    checkOutput("to_err", err, 1);
    checkOutput("to_done", done, 0);
    checkOutput("to_stall", stallCnt, 8);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("to_ignores_start", state, 4);
    checkOutput("to_err_sticky", err, 1);

    // Reset mid-wait returns cleanly to IDLE
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rw_err_cleared", err, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("rw_in_wait", state, 2);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("rw_state", state, 0);
    checkOutput("rw_stall", stallCnt, 0);
    checkOutput("rw_pipe_en", pipeEn, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central pipeline controller for the 5-stage CPU. It sequences fetch start, load-use stalls, taken-branch flushes, whole-pipeline freezes while data memory is not ready, and an orderly drain on a halt instruction. It drives the write enables of the PC and all four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). The forwarding unit and the datapath are unchanged.

## Interface
- DRAIN_CYCLES, 3: bubble cycles needed to retire EX, MEM and WB after a halt.
- MEM_TIMEOUT, 64: maximum consecutive frozen cycles on one memory access before error.
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin execution from IDLE.
- IFID_RSaddr_i  in  5  rs of the instruction in ID.
- IFID_RTaddr_i  in  5  rt of the instruction in ID.
- IFID_uses_rt_i  in  1  ID instruction reads rt.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RTaddr_i  in  5  destination register of the load in EX.
- branch_taken_i  in  1  branch in EX resolved taken.
- halt_i  in  1  halt opcode decoded in ID.
- dmem_req_i  in  1  MEM stage issues a read or write.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID write enable.
- IFID_flush_o  out  1  load NOP into IF/ID.
- IDEX_bubble_o  out  1  zero ID/EX control fields.
- pipe_en_o  out  1  write enable for ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.
- state_o  out  3  current FSM state.
- done_o  out  1  halted normally.
- err_o  out  1  sticky memory-timeout error.

## Operation
FSM states: IDLE=0, RUN=1, MEM_WAIT=2, DRAIN=3, HALTED=4. Outputs are Mealy, combinational from the state and the inputs.

- **IDLE**
  - PCWrite_o, IFIDWrite_o and pipe_en_o are 0. IDEX_bubble_o is 1.
  - start_i causes the transition to RUN.
- **RUN**, evaluated in priority order:
  - **Freeze:** dmem_req_i && !dmem_ready_i.
    - PCWrite_o, IFIDWrite_o and pipe_en_o are 0.
    - Go to MEM_WAIT. Record the return state RUN.
  - **Flush:** branch_taken_i.
    - PCWrite_o=1, IFID_flush_o=1, IDEX_bubble_o=1.
    - Load-use detection and halt_i are ignored, because the ID instruction is wrong-path.
  - **Load-use:** IDEX_MemRead_i && IDEX_RTaddr_i!=0 && (IDEX_RTaddr_i==IFID_RSaddr_i || (IFID_uses_rt_i && IDEX_RTaddr_i==IFID_RTaddr_i)).
    - PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1, pipe_en_o=1.
  - **Halt:** halt_i with no higher-priority condition.
    - Go to DRAIN and clear the drain counter.
  - **Otherwise:** all enables are 1, and flush and bubble are 0.
- **MEM_WAIT**
  - Everything stays frozen while dmem_ready_i=0.
  - On dmem_ready_i=1: that cycle pipe_en_o=1, plus the enables of the return state; the next state is the return state.
- **DRAIN**
  - PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1, pipe_en_o=1.
  - The drain counter increments each unfrozen cycle.
  - After DRAIN_CYCLES unfrozen cycles, go to HALTED.
  - A freeze (the RUN condition) goes to MEM_WAIT with return state DRAIN. The drain counter holds during the freeze.
- **HALTED**
  - All enables are 0 and IDEX_bubble_o=1.
  - done_o=1 unless err_o is set.
  - Only rst_i leaves this state; start_i is ignored.
- **Timeout**
  - The wait counter counts consecutive frozen cycles, including the entry cycle in RUN or DRAIN.
  - When it reaches MEM_TIMEOUT with dmem_ready_i still 0, the next state is HALTED and err_o is set.
- **Stall counter**
  - stall_cnt_o increments by 1 for each load-use cycle and each frozen cycle.
  - It saturates at 2^CNT_W-1.

## Timing
- **Reset:** state=IDLE. PCWrite_o, IFIDWrite_o, IFID_flush_o and pipe_en_o are 0. IDEX_bubble_o=1. stall_cnt_o=0, done_o=0, err_o=0. The drain, wait and return registers are cleared.
- rst_i asserted mid-drain or mid-wait takes effect at the next edge with no other side effects.
- start_i sampled at edge N gives state_o=RUN and PCWrite_o=1 in cycle N+1.
- **Load-use** stalls exactly one cycle. Once the load reaches MEM, the hazard clears with no FSM involvement.
- **Branch flush:** zero-cycle response, with the same-cycle outputs.
- **Memory freeze:** a wait of k cycles with ready low produces exactly k cycles with pipe_en_o=0.
- **Halt:** halt_i at cycle N gives DRAIN in cycles N+1 to N+DRAIN_CYCLES (when unfrozen) and done_o=1 from cycle N+DRAIN_CYCLES+1.

## Structure
- Package cpu_pkg holds:
  - the state enum (3 bits) and its encodings;
  - the constants DRAIN_CYCLES_DEF and MEM_TIMEOUT_DEF;
  - REG_ZERO=5'd0.
- Sub-module load_use_detect (purely combinational) does the register compare for the load-use condition.
- The FSM, the counters and the output decode stay in pipeline_sequencer.

## Test plan
1. **Reset and start:** rst_i high for 1 cycle, start_i high at cycle 3 -> state_o=0 and all enables 0 through cycle 3; state_o=1 and PCWrite_o=1 in cycle 4.
2. **Load-use:** IDEX_MemRead_i=1, IDEX_RTaddr_i=5, IFID_RSaddr_i=5 -> one cycle with PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1; stall_cnt_o goes 0->1. Repeat with IDEX_RTaddr_i=0 -> no stall.
3. **Memory wait:** dmem_req_i=1 with dmem_ready_i=0 for 4 cycles, then 1 -> pipe_en_o=0 for 4 cycles, 1 on the ready cycle; stall_cnt_o +4; back in RUN.
4. **Timeout:** MEM_TIMEOUT=8, dmem_ready_i never asserted -> after 8 frozen cycles state_o=4, err_o=1, done_o=0; start_i is ignored afterwards.
5. **Branch and load-use together:** branch_taken_i=1 with a matching load-use and halt_i=1 -> IFID_flush_o=1, IDEX_bubble_o=1, PCWrite_o=1; stall_cnt_o unchanged; no DRAIN.
6. **Halt with wait mid-drain:** halt_i at cycle N, a 2-cycle memory wait in the 2nd drain cycle -> done_o rises at N+6 instead of N+4.
